// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of the RUN-edge counter: enough to count WIDTH/DIGIT edges from zero.
  function automatic int cnt_w(input int width, input int digit);
    return ((width / digit) <= 2) ? 1 : $clog2(width / digit);
  endfunction

  // Only 1, 2, 4 or 8 bits may be retired per edge, and they must tile the
  // multiplier exactly with at least two digits.
  function automatic bit digit_legal(input int width, input int digit);
    return ((digit == 1) || (digit == 2) || (digit == 4) || (digit == 8)) &&
           ((width % digit) == 0) && (width > digit);
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Operand/product handshake bundle for seq_shift_add_mult.
// MULT_SIGNED_EN adds the is_signed operand qualifier.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 256
) ();

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
`ifdef MULT_SIGNED_EN
  logic               is_signed;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  // Operand source / product sink side.
  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
`ifdef MULT_SIGNED_EN
    output is_signed,
`endif
    input  out_valid,
    output out_ready,
    input  product,
    input  busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
`ifdef MULT_SIGNED_EN
    input  is_signed,
`endif
    output out_valid,
    input  out_ready,
    output product,
    output busy
  );

endinterface

// File: rtl/mult_digit_add.sv
// One shift-add step: acc + mcand*digit, WIDTH+DIGIT bits wide (never overflows).
// Kept separate so a carry-lookahead adder can replace the behavioural '+'.
module mult_digit_add #(
  parameter int WIDTH = 256,
  parameter int DIGIT = 1
) (
  input  logic [WIDTH-1:0]       mcand,
  input  logic [WIDTH-1:0]       acc,
  input  logic [DIGIT-1:0]       digit,
  output logic [WIDTH+DIGIT-1:0] sum
);

  localparam int SW = WIDTH + DIGIT;

  logic [SW-1:0] term [DIGIT];

  // One gated, shifted copy of the multiplicand per multiplier bit in the digit.
  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_term
    assign term[gi] = digit[gi] ? (SW'(mcand) << gi) : '0;
  end

  // Accumulate the partial-product terms onto the running upper half.
  always_comb begin
    sum = SW'(acc);
    for (int i = 0; i < DIGIT; i++) begin
      sum = sum + term[i];
    end
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Multi-cycle shift-add multiplier retiring DIGIT multiplier bits per edge.
// Optional signed mode under macro MULT_SIGNED_EN (adds a NEG fix-up edge).
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int DIGIT = 1
) (
  input logic                 clk,
  input logic                 rst,
  seq_shift_add_mult_if.slave bus
);

  localparam int            N        = WIDTH / DIGIT;
  localparam int            CW       = cnt_w(WIDTH, DIGIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam int            SW       = WIDTH + DIGIT;
  localparam bit            DIGIT_OK = digit_legal(WIDTH, DIGIT);

  if (!DIGIT_OK) begin : g_bad_digit
    $error("seq_shift_add_mult: DIGIT must be 1,2,4,8 and divide WIDTH");
  end

  state_t               state_reg;
  state_t               state_next;
  logic [CW-1:0]        cnt_reg;
  logic [2*WIDTH-1:0]   pp_reg;
  logic [WIDTH-1:0]     mcand_reg;
  logic [SW-1:0]        sum;
  logic [WIDTH-1:0]     a_load;
  logic [WIDTH-1:0]     b_load;
`ifdef MULT_SIGNED_EN
  logic                 sgn_reg;
  logic                 neg_reg;
`endif

  mult_digit_add #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_digit_add (
    .mcand (mcand_reg),
    .acc   (pp_reg[2*WIDTH-1:WIDTH]),
    .digit (pp_reg[DIGIT-1:0]),
    .sum   (sum)
  );

  // Operands as loaded: magnitudes when a signed multiply is requested.
  always_comb begin
    a_load = bus.a;
    b_load = bus.b;
`ifdef MULT_SIGNED_EN
    if (bus.is_signed) begin
      if (bus.a[WIDTH-1]) a_load = -bus.a;
      if (bus.b[WIDTH-1]) b_load = -bus.b;
    end
`endif
  end

  // Next-state logic; in_valid only matters in IDLE, where in_ready is high.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.in_valid) state_next = RUN;
      RUN: begin
        if (cnt_reg == CNT_LAST) begin
`ifdef MULT_SIGNED_EN
          state_next = sgn_reg ? NEG : DONE;
`else
          state_next = DONE;
`endif
        end
      end
      NEG:  state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, counter and datapath registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pp_reg    <= '0;
      mcand_reg <= '0;
`ifdef MULT_SIGNED_EN
      sgn_reg   <= 1'b0;
      neg_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            mcand_reg <= a_load;
            pp_reg    <= {{WIDTH{1'b0}}, b_load};
            cnt_reg   <= '0;
`ifdef MULT_SIGNED_EN
            sgn_reg   <= bus.is_signed;
            neg_reg   <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`endif
          end
        end
        RUN: begin
          pp_reg  <= {sum, pp_reg[WIDTH-1:DIGIT]};
          cnt_reg <= cnt_reg + CW'(1);
        end
`ifdef MULT_SIGNED_EN
        NEG: begin
          if (neg_reg) pp_reg <= -pp_reg;
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches an output.
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.product   = pp_reg;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench: four multipliers (W=8 with D=1,2,4 and W=256 with D=1)
// run the same directed vector list against a plain-arithmetic product model.
module tb_seq_shift_add_mult;

`ifdef MULT_SIGNED_EN
  localparam int NV = 10;
`else
  localparam int NV = 7;
`endif

  logic clk = 1'b0;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  logic [255:0] va   [NV];
  logic [255:0] vb   [NV];
  bit           vs   [NV];
  int           vh   [NV];   // cycles to hold out_ready low after out_valid
  int           vr   [NV];   // nonzero: reset sampled at this RUN edge
  logic [15:0]  lit  [NV];   // hand-computed W=8 product
  bit           lok  [NV];

  localparam logic [511:0] LIT256 = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int inst, input int vec,
                     input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s inst=%0d vec=%0d actual=%0h required=%0h", name, inst, vec, act, exp);
  endtask

  // Product of the low w bits of a and b, optionally as two's complement.
  function automatic logic [511:0] model(input logic [255:0] a, input logic [255:0] b,
                                         input bit sgn, input int w);
    logic [511:0] am, bm, r, m;
    bit na, nb;
    m  = (512'd1 << w) - 512'd1;
    am = {256'b0, a} & m;
    bm = {256'b0, b} & m;
    na = sgn && am[w-1];
    nb = sgn && bm[w-1];
    if (na) am = (512'd1 << w) - am;
    if (nb) bm = (512'd1 << w) - bm;
    r = am * bm;
    if (na ^ nb) r = -r;
    if (w < 256) r = r & ((512'd1 << (2 * w)) - 512'd1);
    return r;
  endfunction

  initial begin
    for (int k = 0; k < NV; k++) begin
      vs[k] = 1'b0; vh[k] = 0; vr[k] = 0; lok[k] = 1'b1;
    end
    va[0] = {256{1'b1}};        vb[0] = {256{1'b1}};  lit[0] = 16'hFE01; vh[0] = 2;
    va[1] = 256'h0;             vb[1] = 256'hA5;      lit[1] = 16'h0000;
    va[2] = 256'hA5;            vb[2] = 256'h0;       lit[2] = 16'h0000;
    va[3] = 256'h1;             vb[3] = 256'h80;      lit[3] = 16'h0080;
    va[4] = 256'h12;            vb[4] = 256'h34;      lit[4] = 16'h03A8; vh[4] = 10;
    va[5] = 256'h0F;            vb[5] = 256'h0F;      lit[5] = 16'h00E1; vr[5] = 2; lok[5] = 1'b0;
    va[6] = 256'h3;             vb[6] = 256'h7;       lit[6] = 16'h0015;
`ifdef MULT_SIGNED_EN
    va[7] = {{248{1'b1}}, 8'hFD}; vb[7] = 256'h5;                 lit[7] = 16'hFFF1; vs[7] = 1'b1;
    va[8] = {{248{1'b1}}, 8'h80}; vb[8] = {{248{1'b1}}, 8'h80};   lit[8] = 16'h4000; vs[8] = 1'b1;
    va[9] = {{248{1'b1}}, 8'hFD}; vb[9] = 256'h5;                 lit[9] = 16'h04F1; vs[9] = 1'b0;
`endif
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int W = (gi == 3) ? 256 : 8;
    localparam int D = (gi == 3) ? 1 : (1 << gi);
    localparam int N = W / D;

    logic         rst_i;
    bit           done_i = 1'b0;
    int           pending = 0;
    int           zero_flag = 1;
    int           exp_first = 0;
    int           cur_vec = 0;
    bit           lit_ok = 1'b0;
    logic [511:0] exp_prod = '0;
    logic [511:0] lit_val = '0;

    seq_shift_add_mult_if #(.WIDTH(W)) bus ();

    seq_shift_add_mult #(
      .WIDTH (W),
      .DIGIT (D)
    ) dut (
      .clk (clk),
      .rst (rst_i),
      .bus (bus)
    );

    // Compare process: every cycle, outputs against the expected phase.
    initial begin
      forever begin
        @(posedge clk);
        #1;
        if (pending == 0) begin
          chk("idle_out_valid", gi, cur_vec, 512'(bus.out_valid), 512'd0);
          chk("idle_in_ready",  gi, cur_vec, 512'(bus.in_ready),  512'd1);
          chk("idle_busy",      gi, cur_vec, 512'(bus.busy),      512'd0);
          if (zero_flag != 0) chk("reset_product", gi, cur_vec, 512'(bus.product), 512'd0);
        end else if (cyc < exp_first) begin
          chk("run_out_valid", gi, cur_vec, 512'(bus.out_valid), 512'd0);
          chk("run_in_ready",  gi, cur_vec, 512'(bus.in_ready),  512'd0);
          chk("run_busy",      gi, cur_vec, 512'(bus.busy),      512'd1);
        end else begin
          chk("done_out_valid", gi, cur_vec, 512'(bus.out_valid), 512'd1);
          chk("done_in_ready",  gi, cur_vec, 512'(bus.in_ready),  512'd0);
          chk("product",        gi, cur_vec, 512'(bus.product),   exp_prod);
          if (cyc == exp_first && lit_ok) chk("product_literal", gi, cur_vec, 512'(bus.product), lit_val);
        end
      end
    end

    // Driver: one directed transaction per vector.
    initial begin : drive
      int t;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
`ifdef MULT_SIGNED_EN
      bus.is_signed = 1'b0;
`endif
      rst_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      for (int k = 0; k < NV; k++) begin
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        cur_vec   = k;
        bus.a     = va[k][W-1:0];
        bus.b     = vb[k][W-1:0];
`ifdef MULT_SIGNED_EN
        bus.is_signed = vs[k];
`endif
        bus.in_valid = 1'b1;
        exp_prod  = model(va[k], vb[k], vs[k], W);
        exp_first = cyc + 1 + N + (vs[k] ? 1 : 0);
        lit_ok    = (W == 8) ? lok[k] : (k == 0);
        lit_val   = (W == 8) ? {496'b0, lit[k]} : LIT256;
        pending   = 1;
        zero_flag = 0;
        @(negedge clk);
        if (vr[k] > 0) begin
          bus.in_valid = 1'b0;
          repeat (vr[k] - 1) @(negedge clk);
          rst_i = 1'b1; pending = 0; zero_flag = 1;
          @(negedge clk);
          rst_i = 1'b0;
          $display("W=%0d D=%0d vec %0d: a=%0h b=%0h aborted by reset at RUN edge %0d",
                   W, D, k, va[k][W-1:0], vb[k][W-1:0], vr[k]);
        end else begin
          // Garbage operands while busy must be ignored, including at release.
          bus.a = W'(8'h5A); bus.b = W'(8'hC3); bus.in_valid = 1'b1;
          t = 0;
          while (bus.out_valid !== 1'b1 && t < 400) begin @(negedge clk); t++; end
          if (t >= 400) begin
            total++;
            $display("FAIL out_valid_timeout inst=%0d vec=%0d: waited %0d cycles, required out_valid", gi, k, t);
          end
          repeat (vh[k]) @(negedge clk);
          bus.out_ready = 1'b1;
          pending = 0;
          $display("W=%0d D=%0d vec %0d: a=%0h b=%0h signed=%0d expected=%0h product=%0h",
                   W, D, k, va[k][W-1:0], vb[k][W-1:0], vs[k], exp_prod, bus.product);
          @(negedge clk);
          bus.out_ready = 1'b0;
          bus.in_valid  = 1'b0;
          if (t >= 400) begin
            rst_i = 1'b1;
            @(negedge clk);
            rst_i = 1'b0;
          end
        end
      end
      @(negedge clk);
      done_i = 1'b1;
    end
  end

  initial begin : main
    int t;
    t = 0;
    while (!(g_dut[0].done_i && g_dut[1].done_i && g_dut[2].done_i && g_dut[3].done_i) && t < 30000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 30000) begin
      total++;
      $display("FAIL run_timeout: %0d cycles elapsed, required all drivers finished", t);
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
